// File: rtl/regression_run_ctrl.sv
// Run sequencer for the linear-regression accelerator. It streams the sample memory twice:
// once into the coefficient calculator, then again (with frozen b0/b1) into the error checker.
module regression_run_ctrl #(
  parameter int N_SAMPLES = 150,
  parameter int DW        = 20,
  parameter int AW        = 8,
  parameter int WAIT_MAX  = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_x,
  input  logic [DW-1:0] mem_y,
  output logic [DW-1:0] x_bus,
  output logic [DW-1:0] y_bus,
  output logic          en_coef,
  output logic          en_err,
  output logic          last,
  input  logic          coeff_done,
  input  logic [DW-1:0] b0_in,
  input  logic [DW-1:0] b1_in,
  output logic [DW-1:0] b0_bus,
  output logic [DW-1:0] b1_bus,
  input  logic          err_done,
  output logic          busy,
  output logic          done,
  output logic          abort,
  output logic [2:0]    state
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [AW:0]   CNT_N     = (AW+1)'(N_SAMPLES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_SAMPLES - 1);
  localparam logic [WW-1:0] WD_LIM    = WW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COEF_LD   = 3'd1,
    S_COEF_WAIT = 3'd2,
    S_LATCH     = 3'd3,
    S_ERR_LD    = 3'd4,
    S_ERR_WAIT  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_rd_q, mem_rd_d;
  logic [DW-1:0] x_q, x_d, y_q, y_d;
  logic          en_coef_q, en_coef_d, en_err_q, en_err_d, last_q, last_d;
  logic [DW-1:0] b0_q, b0_d, b1_q, b1_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          abort_q, abort_d;
  logic          wait_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      en_coef_q  <= 1'b0;
      en_err_q   <= 1'b0;
      last_q     <= 1'b0;
      b0_q       <= '0;
      b1_q       <= '0;
      wd_q       <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      x_q        <= x_d;
      y_q        <= y_d;
      en_coef_q  <= en_coef_d;
      en_err_q   <= en_err_d;
      last_q     <= last_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      wd_q       <= wd_d;
      abort_q    <= abort_d;
    end
  end

  // The compute block's done is only trusted once the final sample has been presented.
  assign wait_done = !last_q &&
                     (((state_q == S_COEF_WAIT) && coeff_done) ||
                      ((state_q == S_ERR_WAIT) && err_done));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    wd_d       = wd_q;
    abort_d    = abort_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    en_coef_d  = mem_rd_q && (state_q == S_COEF_LD);
    en_err_d   = mem_rd_q && (state_q == S_ERR_LD);
    last_d     = mem_rd_q && (mem_addr_q == LAST_ADDR);
    x_d        = mem_rd_q ? mem_x : x_q;
    y_d        = mem_rd_q ? mem_y : y_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COEF_LD;
          cnt_d   = '0;
          abort_d = 1'b0;
        end
      end
      S_COEF_LD, S_ERR_LD: begin
        if (cnt_q == CNT_N) begin
          state_d = (state_q == S_COEF_LD) ? S_COEF_WAIT : S_ERR_WAIT;
          wd_d    = '0;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = cnt_q[AW-1:0];
          cnt_d      = cnt_q + 1'b1;
        end
      end
      S_COEF_WAIT, S_ERR_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (wait_done) begin
          state_d = (state_q == S_COEF_WAIT) ? S_LATCH : S_DONE;
        end else if (wd_q == WD_LIM) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end
      end
      S_LATCH: begin
        b0_d    = b0_in;
        b1_d    = b1_in;
        cnt_d   = '0;
        state_d = S_ERR_LD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign x_bus    = x_q;
  assign y_bus    = y_q;
  assign en_coef  = en_coef_q;
  assign en_err   = en_err_q;
  assign last     = last_q;
  assign b0_bus   = b0_q;
  assign b1_bus   = b1_q;
  assign abort    = abort_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign state    = state_q;

endmodule

// File: tb/tb_regression_run_ctrl.sv
// Directed bench for regression_run_ctrl: per-edge expectation table for a nominal run,
// plus hand sequences for stall, watchdog, reset, ignored start and back-to-back runs.
`timescale 1ns/1ps
module tb_regression_run_ctrl;
  localparam int N  = 4;
  localparam int DW = 20;
  localparam int AW = 4;

  localparam logic [DW-1:0] B0A = 20'h0AAAA, B1A = 20'h05555;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start, mem_rd, en_coef, en_err, last, coeff_done, err_done, busy, done, abort;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_x, mem_y, x_bus, y_bus, b0_in, b1_in, b0_bus, b1_bus;
  logic [2:0] state;

  logic start_w, mem_rd_w, en_coef_w, en_err_w, last_w, coeff_done_w, err_done_w;
  logic busy_w, done_w, abort_w;
  logic [AW-1:0] mem_addr_w;
  logic [DW-1:0] mem_x_w, mem_y_w, x_bus_w, y_bus_w, b0_bus_w, b1_bus_w;
  logic [2:0] state_w;

  function automatic logic [DW-1:0] mx(input logic [AW-1:0] a);
    return 20'h00100 + {16'h0, a} * 20'd3;
  endfunction
  function automatic logic [DW-1:0] my(input logic [AW-1:0] a);
    return 20'h20000 + {16'h0, a} * 20'd7;
  endfunction

  assign mem_x   = mem_rd   ? mx(mem_addr)   : '0;
  assign mem_y   = mem_rd   ? my(mem_addr)   : '0;
  assign mem_x_w = mem_rd_w ? mx(mem_addr_w) : '0;
  assign mem_y_w = mem_rd_w ? my(mem_addr_w) : '0;

  regression_run_ctrl #(.N_SAMPLES(N), .DW(DW), .AW(AW), .WAIT_MAX(64)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_x(mem_x), .mem_y(mem_y), .x_bus(x_bus), .y_bus(y_bus),
    .en_coef(en_coef), .en_err(en_err), .last(last), .coeff_done(coeff_done),
    .b0_in(b0_in), .b1_in(b1_in), .b0_bus(b0_bus), .b1_bus(b1_bus),
    .err_done(err_done), .busy(busy), .done(done), .abort(abort), .state(state));

  regression_run_ctrl #(.N_SAMPLES(N), .DW(DW), .AW(AW), .WAIT_MAX(8)) u_wd (
    .clk(clk), .rst(rst), .start(start_w), .mem_addr(mem_addr_w), .mem_rd(mem_rd_w),
    .mem_x(mem_x_w), .mem_y(mem_y_w), .x_bus(x_bus_w), .y_bus(y_bus_w),
    .en_coef(en_coef_w), .en_err(en_err_w), .last(last_w), .coeff_done(coeff_done_w),
    .b0_in(B0A), .b1_in(B1A), .b0_bus(b0_bus_w), .b1_bus(b1_bus_w),
    .err_done(err_done_w), .busy(busy_w), .done(done_w), .abort(abort_w), .state(state_w));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One row per clock edge after start is accepted (edge 0); addr -1 = don't care.
  typedef struct {
    int st; logic rd; int addr; logic ec; logic ee; logic lst; logic dn; int sidx;
  } vec_t;
  vec_t vtab[17];

  task automatic set_row(input int i, input int st, input logic rd, input int addr,
                         input logic ec, input logic ee, input logic lst, input logic dn,
                         input int sidx);
    vtab[i] = '{st, rd, addr, ec, ee, lst, dn, sidx};
  endtask

  task automatic run_table(input bit pulses);
    start = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (pulses && (i == 2 || i == 13)) start = 1'b1;
      check($sformatf("e%0d state", i), 64'(state), 64'(vtab[i].st));
      check($sformatf("e%0d mem_rd", i), 64'(mem_rd), 64'(vtab[i].rd));
      if (vtab[i].addr >= 0)
        check($sformatf("e%0d mem_addr", i), 64'(mem_addr), 64'(vtab[i].addr));
      check($sformatf("e%0d en_coef", i), 64'(en_coef), 64'(vtab[i].ec));
      check($sformatf("e%0d en_err", i), 64'(en_err), 64'(vtab[i].ee));
      check($sformatf("e%0d last", i), 64'(last), 64'(vtab[i].lst));
      check($sformatf("e%0d done", i), 64'(done), 64'(vtab[i].dn));
      check($sformatf("e%0d busy", i), 64'(busy), 64'(vtab[i].st != 0));
      if (vtab[i].ec || vtab[i].ee) begin
        check($sformatf("e%0d x_bus", i), 64'(x_bus), 64'(mx(AW'(vtab[i].sidx))));
        check($sformatf("e%0d y_bus", i), 64'(y_bus), 64'(my(AW'(vtab[i].sidx))));
      end
      if (i >= 8) begin
        check($sformatf("e%0d b0_bus", i), 64'(b0_bus), 64'(B0A));
        check($sformatf("e%0d b1_bus", i), 64'(b1_bus), 64'(B1A));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n2, nd, ncoef, nerr, cidx, eidx;
    int ra[$];
    int de[$];
    logic [2:0] hold_st;

    set_row(0, 1, 0, -1, 0, 0, 0, 0, 0);
    set_row(1, 1, 1, 0, 0, 0, 0, 0, 0);
    set_row(2, 1, 1, 1, 1, 0, 0, 0, 0);
    set_row(3, 1, 1, 2, 1, 0, 0, 0, 1);
    set_row(4, 1, 1, 3, 1, 0, 0, 0, 2);
    set_row(5, 2, 0, 3, 1, 0, 1, 0, 3);
    set_row(6, 2, 0, 3, 0, 0, 0, 0, 0);
    set_row(7, 3, 0, 3, 0, 0, 0, 0, 0);
    set_row(8, 4, 0, 3, 0, 0, 0, 0, 0);
    set_row(9, 4, 1, 0, 0, 0, 0, 0, 0);
    set_row(10, 4, 1, 1, 0, 1, 0, 0, 0);
    set_row(11, 4, 1, 2, 0, 1, 0, 0, 1);
    set_row(12, 4, 1, 3, 0, 1, 0, 0, 2);
    set_row(13, 5, 0, 3, 0, 1, 1, 0, 3);
    set_row(14, 5, 0, 3, 0, 0, 0, 0, 0);
    set_row(15, 6, 0, 3, 0, 0, 0, 1, 0);
    set_row(16, 0, 0, 3, 0, 0, 0, 0, 0);

    rst = 1'b0;
    start = 1'b0; coeff_done = 1'b1; err_done = 1'b1; b0_in = B0A; b1_in = B1A;
    start_w = 1'b0; coeff_done_w = 1'b1; err_done_w = 1'b0;
    repeat (3) @(negedge clk);
    check("reset state", 64'(state), 64'd0);
    check("reset outputs", {mem_addr, mem_rd, x_bus, y_bus, en_coef, en_err, last,
                            b0_bus, b1_bus, busy, done, abort}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Nominal run, then the same run with start pulsed in COEF_LD and ERR_WAIT.
    run_table(1'b0);
    run_table(1'b1);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || state != 3'd0) nd++;
    end
    check("no extra run after ignored starts", 64'(nd), 64'd0);

    // coeff_done arrives 20 cycles after pass 1 ends; late b0_in changes must not leak.
    coeff_done = 1'b0;
    b0_in = 20'h11111; b1_in = 20'h22222;
    start = 1'b1;
    n2 = 0;
    for (int e = 0; e <= 27; e++) begin
      @(negedge clk);
      start = 1'b0;
      if (e >= 6 && e <= 25 && state == 3'd2) n2++;
      if (e == 25) coeff_done = 1'b1;
      if (e == 26) begin
        check("stall latch state", 64'(state), 64'd3);
        b0_in = 20'h33333; b1_in = 20'h44444;
      end
      if (e == 27) begin
        check("stall b0_bus", 64'(b0_bus), 64'h33333);
        check("stall b1_bus", 64'(b1_bus), 64'h44444);
        b0_in = 20'h55555; b1_in = 20'h66666;
      end
    end
    check("coef_wait hold cycles", 64'(n2), 64'd20);
    nd = 0;
    for (int i = 0; i < 20 && nd == 0; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("stall run done", 64'(nd), 64'd1);
    check("b0_bus held after late change", 64'(b0_bus), 64'h33333);
    b0_in = B0A; b1_in = B1A;
    @(negedge clk);

    // Reset in ERR_LD at addr 2, then a fresh start.
    start = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre-reset state", 64'(state), 64'd4);
    check("pre-reset addr", 64'(mem_addr), 64'd2);
    rst = 1'b0;
    #1;
    check("mid-run reset state", 64'(state), 64'd0);
    check("mid-run reset outputs", {mem_addr, mem_rd, x_bus, y_bus, en_coef, en_err, last,
                                    b0_bus, b1_bus, busy, done, abort}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (state != 3'd0 || mem_rd) nd++;
    end
    check("idle after reset without start", 64'(nd), 64'd0);
    run_table(1'b0);

    // Back-to-back runs with start held high.
    start = 1'b1;
    ncoef = 0; nerr = 0; cidx = 0; eidx = 0;
    for (int e = 0; e <= 34; e++) begin
      @(negedge clk);
      if (e == 17) start = 1'b0;
      if (mem_rd) ra.push_back(int'(mem_addr));
      if (done) de.push_back(e);
      if (en_coef && en_err) check("en_coef and en_err overlap", 64'd1, 64'd0);
      if (en_coef) begin
        check($sformatf("b2b coef x #%0d", ncoef), 64'(x_bus), 64'(mx(AW'(cidx % N))));
        ncoef++; cidx++;
      end
      if (en_err) begin
        check($sformatf("b2b err y #%0d", nerr), 64'(y_bus), 64'(my(AW'(eidx % N))));
        nerr++; eidx++;
      end
    end
    check("b2b read count", 64'(ra.size()), 64'd16);
    foreach (ra[k]) check($sformatf("b2b read addr #%0d", k), 64'(ra[k]), 64'(k % N));
    check("b2b en_coef count", 64'(ncoef), 64'd8);
    check("b2b en_err count", 64'(nerr), 64'd8);
    check("b2b done count", 64'(de.size()), 64'd2);
    if (de.size() == 2) begin
      check("b2b first done edge", 64'(de[0]), 64'd15);
      check("b2b second done edge", 64'(de[1]), 64'd32);
    end

    // Watchdog (WAIT_MAX=8) expires in ERR_WAIT.
    start_w = 1'b1;
    nd = 0;
    for (int e = 0; e <= 21; e++) begin
      @(negedge clk);
      start_w = 1'b0;
      if (done_w) nd++;
      if (e == 20) begin
        check("wd state before expiry", 64'(state_w), 64'd5);
        check("wd abort before expiry", 64'(abort_w), 64'd0);
      end
    end
    check("wd state after expiry", 64'(state_w), 64'd0);
    check("wd abort after expiry", 64'(abort_w), 64'd1);
    check("wd busy after expiry", 64'(busy_w), 64'd0);
    repeat (3) @(negedge clk);
    check("wd abort sticky", 64'(abort_w), 64'd1);
    check("wd no done pulse", 64'(nd), 64'd0);

    // New start clears abort; coeff_done lands on the watchdog's final cycle.
    coeff_done_w = 1'b0; err_done_w = 1'b1;
    start_w = 1'b1;
    for (int e = 0; e <= 13; e++) begin
      @(negedge clk);
      start_w = 1'b0;
      if (e == 0) check("wd abort cleared by start", 64'(abort_w), 64'd0);
      if (e == 12) coeff_done_w = 1'b1;
    end
    hold_st = state_w;
    check("done beats watchdog state", 64'(hold_st), 64'd3);
    check("done beats watchdog abort", 64'(abort_w), 64'd0);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_w) nd++;
    end
    check("wd rerun done count", 64'(nd), 64'd1);
    check("wd rerun abort", 64'(abort_w), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regression_run_ctrl.md
# regression_run_ctrl

Top-level sequencer for the linear-regression accelerator. Owns the sample-memory read port and runs two passes over the dataset. Pass 1 streams every (x, y) pair into the coefficient calculator, then captures b0/b1. Pass 2 streams the same pairs plus the frozen coefficients into the error checker. It sits between the sample memory and the two compute drivers and replaces ad-hoc enable/done wiring with one FSM that has a watchdog.

## Interface
Parameters:
- N_SAMPLES, 150, samples per run (≥2)
- DW, 20, sample and coefficient width
- AW, 8, memory address width (2^AW ≥ N_SAMPLES)
- WAIT_MAX, 1023, max cycles to wait for a compute block's done before aborting

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- start  in  1  run request, sampled in IDLE only
- mem_addr  out  AW  sample-memory address
- mem_rd  out  1  memory read strobe; synchronous memory, data valid next cycle
- mem_x, mem_y  in  DW  memory read data
- x_bus, y_bus  out  DW  sample stream to both compute blocks (registered copy of mem_x/mem_y)
- en_coef  out  1  x_bus/y_bus valid for coefficient calculator
- en_err  out  1  x_bus/y_bus valid for error checker
- last  out  1  qualifies the final sample of a pass (with en_coef or en_err)
- coeff_done  in  1  level; coefficient calculator has b0/b1 ready
- b0_in, b1_in  in  DW  coefficients from calculator
- b0_bus, b1_bus  out  DW  latched coefficients to error checker
- err_done  in  1  level; error checker finished
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at successful end of run
- abort  out  1  sticky; set on watchdog expiry, cleared by next accepted start
- state  out  3  current FSM state encoding, for debug

## Operation
- States: IDLE=0, COEF_LD=1, COEF_WAIT=2, LATCH=3, ERR_LD=4, ERR_WAIT=5, DONE=6.
- IDLE: start=1 → COEF_LD. In the same edge: addr counter←0, abort←0.
- COEF_LD and ERR_LD each issue N_SAMPLES reads.
  - mem_rd=1 with mem_addr = 0..N_SAMPLES-1, one address per cycle, no gaps.
  - After issuing address N_SAMPLES-1 → COEF_WAIT or ERR_WAIT respectively.
- Data pipeline: one register stage.
  - The en_coef/en_err/last flags are delayed one cycle from mem_rd so they align with x_bus/y_bus.
  - The last sample's enable appears in the first cycle of the WAIT state.
- COEF_WAIT: ignores coeff_done during the cycle the last sample is presented.
  - Afterwards coeff_done=1 → LATCH.
- LATCH: b0_bus←b0_in and b1_bus←b1_in, then → ERR_LD.
  - b0_bus/b1_bus hold their value until the next LATCH or reset.
- ERR_WAIT: same rule as COEF_WAIT. err_done=1 → DONE.
- DONE: done=1 for one cycle, then → IDLE.
- Watchdog:
  - The cycle counter clears on entry to each WAIT state and increments every cycle in it.
  - Reaching WAIT_MAX without the done input → abort←1, → IDLE. No done pulse.
- start while busy is ignored; it is not queued.
- mem_addr holds its last value when mem_rd=0.

## Timing
- Reset values (asynchronous, on rst=0): state=IDLE; mem_addr=0, mem_rd=0; x_bus=y_bus=0; en_coef=en_err=last=0; b0_bus=b1_bus=0; busy=0, done=0, abort=0; watchdog counter=0.
- Reset mid-run drops every output to its reset value immediately. The next run needs a fresh start.
- Cycle latencies, with start accepted at edge 0:
  - Edge 1: mem_rd=1, addr 0.
  - Edges 2..N+1: en_coef=1.
  - last=1 at edge N+1.
- With coeff_done already high:
  - COEF_WAIT exits at the edge after the last sample.
  - LATCH takes 1 cycle.
  - Pass 2 mirrors pass 1.
- Minimum run start→done is 2N+7 cycles.
- en_coef and en_err are never high in the same cycle. last is never high without one of them.
- coeff_done and the watchdog hitting WAIT_MAX in the same cycle: done wins, no abort.

## Test plan
- Nominal run, N_SAMPLES=4, coeff_done and err_done tied high:
  - en_coef high edges 2–5 with x_bus = mem contents at addr 0..3; last at edge 5.
  - b0_bus/b1_bus update at the LATCH edge.
  - en_err high for 4 cycles; done pulses once at edge 15 (2N+7).
- coeff_done asserted 20 cycles after pass 1 ends:
  - State holds 2 for 20 cycles, then LATCH.
  - b0_bus equals b0_in sampled at that edge; later b0_in changes do not propagate.
- Watchdog, WAIT_MAX=8, err_done held low:
  - abort=1 after 8 cycles in ERR_WAIT, state=IDLE, no done pulse.
  - A new start clears abort and the run completes normally.
- start pulsed during COEF_LD and ERR_WAIT: no effect on address sequence or state; exactly one done.
- rst=0 asserted mid-ERR_LD at addr 2: all outputs zero on the same edge, state=IDLE. The run restarts at addr 0 only after the next start.
- Back-to-back runs with start held high: second run begins the cycle after DONE with addr 0, no missed or duplicated samples.
